sobel_stream_core: RTL and testbench
====================================

# sobel_stream_core

Parametrised streaming Sobel edge core: accepts one raster-order pixel per handshake, keeps two line buffers plus a 3x3 window, and emits gradient-magnitude pixels for every interior position of an `IMG_W` x `IMG_H` frame. It replaces the fixed 4x4-block buffer/convolution/magnitude chain behind the AHB slave with a single pipelined, back-pressurable datapath. It also adds a brightness gain and frame framing/error flags.

## Interface
- `PIX_W`, default 4: input and output pixel width (unsigned).
- `IMG_W`, default 16: frame width in pixels, must be at least 3.
- `IMG_H`, default 16: frame height in pixels, must be at least 3.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input pixel present.
- `in_ready` out 1: core can accept a pixel.
- `in_pixel` in PIX_W: input pixel value.
- `in_sof` in 1: qualifies `in_pixel` as pixel (0,0) of a frame.
- `gain` in 4: magnitude gain in quarter steps (4 = unity). Sampled with each accepted pixel.
- `out_valid` out 1: `out_pixel` holds a result.
- `out_ready` in 1: downstream accepts the result.
- `out_pixel` out PIX_W: edge magnitude.
- `out_eof` out 1: qualifies the last interior result of a complete frame.
- `err_sof` out 1: one-cycle pulse when `in_sof` arrives mid-frame.

## Operation
- **Reset values.** Every output is 0 except `in_ready`, which is 1. Reset clears the FSM, counters, window, pipeline valids and line buffers.
- **Acceptance.** A pixel is accepted when `in_valid && in_ready` at a rising edge.
- **Frame FSM.** There are two states, IDLE and ACTIVE.
  - IDLE: an accepted pixel with `in_sof=1` becomes pixel (0,0) and moves the FSM to ACTIVE. An accepted pixel with `in_sof=0` is consumed and discarded.
  - ACTIVE: `col` counts up on each accepted pixel and wraps at `IMG_W-1`, which increments `row`. Acceptance of pixel (`IMG_H-1`,`IMG_W-1`) returns the FSM to IDLE.
  - ACTIVE with `in_sof=1` at any position other than (0,0): `err_sof` pulses, that pixel becomes the new (0,0), and the FSM stays in ACTIVE. Results already in flight drain normally. The truncated frame never asserts `out_eof`.
- **Line buffers.** Two `IMG_W`-deep rows are written at `col`. The 3x3 window shifts left on every accepted pixel.
- **Window validity.** A window is valid when `row>=2 && col>=2`. Its centre is (`row-1`,`col-1`). Outputs are produced in raster order of interior pixels, (`IMG_W-2`)*(`IMG_H-2`) per frame.
- **Gradients.** With window element p[r][c]:
  - gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20)
  - gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02)
  - Both are signed, PIX_W+3 bits.
- **Magnitude.** mag = |gx| + |gy|, unsigned, PIX_W+3 bits, computed without wrap.
- **Scaling.** scaled = (mag · gain) >> 2. The result saturates to 2^PIX_W − 1.
- **End of frame.** `out_eof` rides with the result whose centre is (`IMG_H-2`,`IMG_W-2`), and only in a frame that began with `in_sof` and was not restarted.

## Timing
- **Pipeline stages.**
  - A: window and line-buffer write on the accepting edge N.
  - B: gx and gy registered on edge N+1.
  - C: `out_pixel` and `out_valid` registered on edge N+2.
- **Latency.** With no back-pressure, the result is visible in the cycle after edge N+2.
- **Stall.** stall = `out_valid && !out_ready`. During a stall every stage holds and `in_ready` = 0. `in_ready` depends combinationally on `out_ready`. Throughput is one pixel per clock when `out_ready` = 1.
- **Output stability.** `out_pixel` and `out_eof` are held stable while `out_valid && !out_ready`.
- **Reset mid-frame.** In-flight results are discarded. `out_valid` is 0 on the cycle after the reset edge.
- **Simultaneous events.** A stall and a mid-frame `in_sof` can coincide. The pixel is not accepted, so no `err_sof` fires until it is accepted.

## Configuration
- **`SOBEL_THRESH_EN` defined.**
  - Adds input port `thresh` (PIX_W bits), sampled with each accepted pixel.
  - `out_pixel` = all-ones when scaled >= `thresh`, otherwise 0.
  - This adds no extra latency.
- **`SOBEL_THRESH_EN` undefined.** The `thresh` port is absent and `out_pixel` is the saturated scaled magnitude.

## Test plan
All scenarios use PIX_W=4, IMG_W=IMG_H=4.
- **Vertical step.** Columns 0,1 = 0 and columns 2,3 = 15 in every row, gain=4, `out_ready`=1 → 4 outputs of 15. `out_eof` is set on the 4th output. The first `out_valid` appears 2 edges after accepting pixel (2,2).
- **Ramp and gain.** Columns 0,0,1,1, gain=4 → outputs 4,4,4,4. The same frame with gain=2 → 2,2,2,2. With gain=0 → 0,0,0,0.
- **Flat field.** Uniform 7 → four 0 outputs, `out_eof` on the last.
- **Back-pressure.** Hold `out_ready`=0 for 5 cycles once `out_valid` rises → `in_ready`=0 and `out_pixel` stable throughout. After release the output sequence is identical to the unstalled run.
- **Framing errors.**
  - 3 pixels sent without `in_sof` while IDLE → no outputs.
  - `in_sof` at pixel (1,2) → `err_sof` = 1 for exactly one cycle, the frame restarts, and `out_eof` appears only for the restarted full frame.
- **Threshold (`SOBEL_THRESH_EN`).** Ramp frame with `thresh`=4 → 15,15,15,15. With `thresh`=5 → 0,0,0,0.

Source files
------------

// File: rtl/sobel_stream_core_if.sv
// Stream bundle for sobel_stream_core: pixel input handshake, result output handshake, gain and status.
// With SOBEL_THRESH_EN defined the bundle also carries the per-pixel threshold.
interface sobel_stream_core_if #(
  parameter int PIX_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             in_sof;
  logic [3:0]       gain;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_eof;
  logic             err_sof;
`ifdef SOBEL_THRESH_EN
  logic [PIX_W-1:0] thresh;

  modport slave (
    input  in_valid, in_pixel, in_sof, gain, thresh, out_ready,
    output in_ready, out_valid, out_pixel, out_eof, err_sof
  );
  modport master (
    output in_valid, in_pixel, in_sof, gain, thresh, out_ready,
    input  in_ready, out_valid, out_pixel, out_eof, err_sof
  );
`else
  modport slave (
    input  in_valid, in_pixel, in_sof, gain, out_ready,
    output in_ready, out_valid, out_pixel, out_eof, err_sof
  );
  modport master (
    output in_valid, in_pixel, in_sof, gain, out_ready,
    input  in_ready, out_valid, out_pixel, out_eof, err_sof
  );
`endif
endinterface

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel edge core: two line buffers, 3x3 window, three-stage back-pressurable datapath.
// Optional SOBEL_THRESH_EN: binarise the scaled magnitude against the per-pixel thresh input.
module sobel_stream_core #(
  parameter int PIX_W = 4,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input logic clk,
  input logic rst,
  sobel_stream_core_if.slave s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;
  localparam int PW = GW + 4;
  localparam logic [PW-1:0] PIX_MAX = PW'((1 << PIX_W) - 1);

  function automatic logic signed [GW-1:0] tap_sum(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b,
                                                   input logic [PIX_W-1:0] c);
    logic signed [GW-1:0] ea, eb, ec;
    ea = $signed({3'b000, a});
    eb = $signed({3'b000, b});
    ec = $signed({3'b000, c});
    return ea + (eb <<< 1) + ec;
  endfunction

  function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
    logic signed [GW-1:0] n;
    n = -v;
    return v[GW-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  // Gain is in quarter steps; the product cannot wrap in PW bits.
  function automatic logic [PIX_W-1:0] scale_sat(input logic [GW-1:0] mag,
                                                 input logic [3:0] g);
    logic [PW-1:0] sh;
    sh = (PW'(mag) * PW'(g)) >> 2;
    return (sh > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : sh[PIX_W-1:0];
  endfunction

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state;
  logic [CW-1:0]        col, pcol;
  logic [RW-1:0]        row, prow;
  logic                 stall, accept, take, restart;
  logic [PIX_W-1:0]     lb0 [IMG_W];
  logic [PIX_W-1:0]     lb1 [IMG_W];
  logic [PIX_W-1:0]     win [3][3];
  logic                 vld_p0, eof_p0, vld_p1, eof_p1;
  logic [3:0]           gain_p0, gain_p1;
  logic signed [GW-1:0] gx_p1, gy_p1;
  logic [GW-1:0]        mag;
  logic [PIX_W-1:0]     scaled, pix_next;
`ifdef SOBEL_THRESH_EN
  logic [PIX_W-1:0]     thr_p0, thr_p1;
`endif

  assign stall      = s.out_valid && !s.out_ready;
  assign s.in_ready = !stall;
  assign accept     = s.in_valid && !stall;
  // Pixels arriving in IDLE without a start-of-frame marker are swallowed.
  assign take       = accept && (state == ACTIVE || s.in_sof);
  assign restart    = accept && (state == ACTIVE) && s.in_sof && (col != '0 || row != '0);
  assign pcol       = s.in_sof ? '0 : col;
  assign prow       = s.in_sof ? '0 : row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      s.err_sof <= 1'b0;
    end else begin
      s.err_sof <= restart;
      if (take) begin
        if (pcol == CW'(IMG_W - 1)) begin
          col <= '0;
          if (prow == RW'(IMG_H - 1)) begin
            row   <= '0;
            state <= IDLE;
          end else begin
            row   <= prow + 1'b1;
            state <= ACTIVE;
          end
        end else begin
          col   <= pcol + 1'b1;
          row   <= prow;
          state <= ACTIVE;
        end
      end
    end
  end

  // Stage A: line buffers and window advance on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      vld_p0 <= 1'b0;
      eof_p0 <= 1'b0;
    end else if (!stall) begin
      vld_p0 <= take && (prow >= RW'(2)) && (pcol >= CW'(2));
      eof_p0 <= take && (prow == RW'(IMG_H - 1)) && (pcol == CW'(IMG_W - 1));
      if (take) begin
        lb1[pcol] <= lb0[pcol];
        lb0[pcol] <= s.in_pixel;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1[pcol];
        win[1][2] <= lb0[pcol];
        win[2][2] <= s.in_pixel;
      end
    end
  end

  // Stage B: gradients; data registers carry no reset.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (take) begin
        gain_p0 <= s.gain;
`ifdef SOBEL_THRESH_EN
        thr_p0  <= s.thresh;
`endif
      end
      gx_p1   <= tap_sum(win[0][2], win[1][2], win[2][2]) - tap_sum(win[0][0], win[1][0], win[2][0]);
      gy_p1   <= tap_sum(win[2][0], win[2][1], win[2][2]) - tap_sum(win[0][0], win[0][1], win[0][2]);
      gain_p1 <= gain_p0;
`ifdef SOBEL_THRESH_EN
      thr_p1  <= thr_p0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= vld_p0;
      eof_p1 <= eof_p0;
    end
  end

  assign mag    = abs_val(gx_p1) + abs_val(gy_p1);
  assign scaled = scale_sat(mag, gain_p1);
`ifdef SOBEL_THRESH_EN
  assign pix_next = (scaled >= thr_p1) ? '1 : '0;
`else
  assign pix_next = scaled;
`endif

  // Stage C: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s.out_valid <= 1'b0;
      s.out_pixel <= '0;
      s.out_eof   <= 1'b0;
    end else if (!stall) begin
      s.out_valid <= vld_p1;
      s.out_pixel <= pix_next;
      s.out_eof   <= vld_p1 && eof_p1;
    end
  end
endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed bench for sobel_stream_core on 4x4 frames: table of frames plus stall, framing and reset sequences.
module tb_sobel_stream_core;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sobel_stream_core_if #(.PIX_W(PW)) sif();
  sobel_stream_core #(.PIX_W(PW), .IMG_W(4), .IMG_H(4)) dut (.clk(clk), .rst(rst), .s(sif));

  typedef struct packed {
    logic [63:0] pix;
    logic [3:0]  gain;
    logic [3:0]  thr;
    logic [15:0] exp;
    logic [15:0] exp_thr;
  } vec_t;

  vec_t       vecs [11];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         err_cnt = 0;
  int         first_vld = -1;
  int         acc10 = 0;
  int         last_acc = 0;
  logic [4:0] outq [$];

  function automatic logic [15:0] pk(input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c, input logic [3:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] frame_cols(input logic [15:0] r);
    return {4{r}};
  endfunction

  function automatic logic [63:0] frame_rows(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c, input logic [3:0] d);
    return {{4{d}}, {4{c}}, {4{b}}, {4{a}}};
  endfunction

  function automatic logic [15:0] pick(input vec_t v);
`ifdef SOBEL_THRESH_EN
    return v.exp_thr;
`else
    return v.exp;
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (sif.out_valid === 1'b1 && first_vld < 0) first_vld = cyc;
    if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) outq.push_back({sif.out_eof, sif.out_pixel});
    if (sif.err_sof === 1'b1) err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] p, input logic sof, input logic [3:0] g, input logic [3:0] t);
    bit rdy;
    int n;
    sif.in_valid = 1'b1;
    sif.in_pixel = p;
    sif.in_sof   = sof;
    sif.gain     = g;
`ifdef SOBEL_THRESH_EN
    sif.thresh   = t;
`endif
    n = 0;
    forever begin
      @(negedge clk);
      rdy = sif.in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        check("send_timeout", n, 0);
        break;
      end
    end
    #1;
    sif.in_valid = 1'b0;
    sif.in_sof   = 1'b0;
    last_acc     = cyc;
  endtask

  task automatic check_outs(input logic [15:0] exp, input string nm);
    check({nm, "_cnt"}, outq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < outq.size()) begin
        check($sformatf("%s_px%0d", nm, k), int'(outq[k][3:0]), int'(exp[4*k +: 4]));
        check($sformatf("%s_eof%0d", nm, k), int'(outq[k][4]), (k == 3) ? 1 : 0);
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    outq.delete();
    first_vld = -1;
    for (int i = 0; i < 16; i++) begin
      send(v.pix[4*i +: 4], (i == 0), v.gain, v.thr);
      if (i == 10) acc10 = last_acc;
    end
    repeat (6) @(posedge clk);
    #1;
    check_outs(pick(v), nm);
    check({nm, "_lat"}, first_vld, acc10 + 2);
  endtask

  initial begin
    logic [15:0] bp_exp;
    logic [3:0]  held;
    int          n;

    sif.in_valid  = 1'b0;
    sif.in_pixel  = '0;
    sif.in_sof    = 1'b0;
    sif.gain      = 4'd4;
    sif.out_ready = 1'b1;
`ifdef SOBEL_THRESH_EN
    sif.thresh    = '0;
`endif
    rst = 1'b1;

    vecs[0]  = '{frame_cols(pk(0, 0, 15, 15)), 4'd4, 4'd4, pk(15, 15, 15, 15), pk(15, 15, 15, 15)};
    vecs[1]  = '{frame_cols(pk(0, 0, 1, 1)),   4'd4, 4'd4, pk(4, 4, 4, 4),     pk(15, 15, 15, 15)};
    vecs[2]  = '{frame_cols(pk(0, 0, 1, 1)),   4'd2, 4'd4, pk(2, 2, 2, 2),     pk(0, 0, 0, 0)};
    vecs[3]  = '{frame_cols(pk(0, 0, 1, 1)),   4'd0, 4'd4, pk(0, 0, 0, 0),     pk(0, 0, 0, 0)};
    vecs[4]  = '{frame_cols(pk(0, 0, 1, 1)),   4'd4, 4'd5, pk(4, 4, 4, 4),     pk(0, 0, 0, 0)};
    vecs[5]  = '{frame_cols(pk(7, 7, 7, 7)),   4'd4, 4'd4, pk(0, 0, 0, 0),     pk(0, 0, 0, 0)};
    vecs[6]  = '{frame_cols(pk(15, 15, 0, 0)), 4'd4, 4'd4, pk(15, 15, 15, 15), pk(15, 15, 15, 15)};
    vecs[7]  = '{{pk(0, 1, 2, 3), pk(0, 0, 1, 2), pk(0, 0, 0, 0), pk(0, 0, 0, 0)},
                 4'd4, 4'd4, pk(2, 6, 8, 14), pk(0, 15, 15, 15)};
    vecs[8]  = '{{pk(0, 1, 2, 3), pk(0, 0, 1, 2), pk(0, 0, 0, 0), pk(0, 0, 0, 0)},
                 4'd8, 4'd4, pk(4, 12, 15, 15), pk(15, 15, 15, 15)};
    vecs[9]  = '{frame_rows(0, 0, 1, 1),       4'd3, 4'd4, pk(3, 3, 3, 3),     pk(0, 0, 0, 0)};
    vecs[10] = '{frame_rows(15, 15, 0, 0),     4'd1, 4'd4, pk(15, 15, 15, 15), pk(15, 15, 15, 15)};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(sif.in_ready), 1);
    check("rst_out_valid", int'(sif.out_valid), 0);
    check("rst_out_pixel", int'(sif.out_pixel), 0);
    check("rst_out_eof", int'(sif.out_eof), 0);
    check("rst_err_sof", int'(sif.err_sof), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    err_cnt = 0;

    for (int v = 0; v < 11; v++) run_frame(vecs[v], $sformatf("vec%0d", v));
    check("clean_err_cnt", err_cnt, 0);

    // Pixels without a start marker while idle are discarded.
    outq.delete();
    for (int i = 0; i < 3; i++) send(4'd15, 1'b0, 4'd4, 4'd4);
    repeat (6) @(posedge clk);
    #1;
    check("idle_no_out", outq.size(), 0);

    // Back-pressure: stall five cycles on the first result.
    outq.delete();
    bp_exp = pick(vecs[7]);
    held   = '0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(vecs[7].pix[4*i +: 4], (i == 0), vecs[7].gain, vecs[7].thr);
      end
      begin
        n = 0;
        while (sif.out_valid !== 1'b1 && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("bp_valid_seen", int'(sif.out_valid), 1);
        sif.out_ready = 1'b0;
        held = sif.out_pixel;
        check("bp_first_px", int'(held), int'(bp_exp[3:0]));
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check($sformatf("bp_in_ready%0d", k), int'(sif.in_ready), 0);
          check($sformatf("bp_hold%0d", k), int'(sif.out_pixel), int'(held));
          check($sformatf("bp_valid%0d", k), int'(sif.out_valid), 1);
        end
        @(posedge clk);
        #1;
        sif.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check_outs(bp_exp, "bp");

    // Restart at (1,2): the restarted frame is the only one that completes.
    outq.delete();
    err_cnt = 0;
    for (int i = 0; i < 6; i++) send(vecs[0].pix[4*i +: 4], (i == 0), 4'd4, 4'd4);
    for (int i = 0; i < 16; i++) send(vecs[0].pix[4*i +: 4], (i == 0), 4'd4, 4'd4);
    repeat (6) @(posedge clk);
    #1;
    check("restart_err_cycles", err_cnt, 1);
    check_outs(pick(vecs[0]), "restart");

    // Reset with results in flight.
    outq.delete();
    for (int i = 0; i < 12; i++) send(vecs[0].pix[4*i +: 4], (i == 0), 4'd4, 4'd4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", int'(sif.out_valid), 0);
    check("midrst_in_ready", int'(sif.in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_out", outq.size(), 0);
    run_frame(vecs[7], "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
